// File: rtl/pll_lock_supervisor_if.sv
// PLL handshake and system-reset bundle between the supervisor and the PLL/system side.
interface pll_lock_supervisor_if;
  logic       locked;
  logic       clear_status;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic       lock_lost;
  logic [3:0] retry_cnt;

  modport master (
    input  locked, clear_status,
    output pll_rst, sys_rst_n, ready, fault, lock_lost, retry_cnt
  );

  modport slave (
    output locked, clear_status,
    input  pll_rst, sys_rst_n, ready, fault, lock_lost, retry_cnt
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable synchronised lock, then releases the system reset.
// Retries on lock timeout, faults after MAX_RETRIES, and re-resets everything on lock loss.
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 7
) (
  input  logic                   refclk,
  input  logic                   rst_n,
  pll_lock_supervisor_if.master  bus
);

  localparam int unsigned MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
  localparam int          CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t             state, nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [3:0]         retry, retry_nxt;
  logic               lost, lost_nxt, lost_set;
  logic [1:0]         sync_pipe;
  logic               locked_s;

  assign locked_s = sync_pipe[1];

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[0], bus.locked};
  end

  always_comb begin
    nxt       = state;
    cnt_nxt   = cnt + 1'b1;
    retry_nxt = retry;
    lost_set  = 1'b0;
    case (state)
      S_RESET_PLL: begin
        if (cnt == CNT_W'(RST_PULSE_CYCLES - 1)) begin
          nxt     = S_WAIT_LOCK;
          cnt_nxt = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          nxt     = S_STABILIZE;
          cnt_nxt = '0;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          cnt_nxt = '0;
          if (retry == 4'(MAX_RETRIES)) begin
            nxt = S_FAULT;
          end else begin
            nxt       = S_RESET_PLL;
            retry_nxt = retry + 4'd1;
          end
        end
      end
      S_STABILIZE: begin
        // A single dropped lock sample restarts the whole wait, timeout included.
        if (!locked_s) begin
          nxt     = S_WAIT_LOCK;
          cnt_nxt = '0;
        end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          nxt       = S_RUN;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      end
      S_RUN: begin
        cnt_nxt = '0;
        if (!locked_s) begin
          nxt      = S_RESET_PLL;
          lost_set = 1'b1;
        end
      end
      S_FAULT: begin
        cnt_nxt = '0;
        if (bus.clear_status) begin
          nxt       = S_RESET_PLL;
          retry_nxt = '0;
        end
      end
      default: begin
        nxt     = S_RESET_PLL;
        cnt_nxt = '0;
      end
    endcase

    // A lock-loss event on the same cycle as a clear must stay visible.
    lost_nxt = lost;
    if (bus.clear_status) lost_nxt = 1'b0;
    if (lost_set)         lost_nxt = 1'b1;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_RESET_PLL;
      cnt           <= '0;
      retry         <= '0;
      lost          <= 1'b0;
      bus.pll_rst   <= 1'b1;
      bus.sys_rst_n <= 1'b0;
      bus.ready     <= 1'b0;
      bus.fault     <= 1'b0;
    end else begin
      state         <= nxt;
      cnt           <= cnt_nxt;
      retry         <= retry_nxt;
      lost          <= lost_nxt;
      bus.pll_rst   <= (nxt == S_RESET_PLL) || (nxt == S_FAULT);
      bus.sys_rst_n <= (nxt == S_RUN);
      bus.ready     <= (nxt == S_RUN);
      bus.fault     <= (nxt == S_FAULT);
    end
  end

  assign bus.lock_lost = lost;
  assign bus.retry_cnt = retry;

endmodule
